seg7_scan_reader: RTL and testbench
===================================

// Module: seg7_scan_reader
// PURPOSE
//  Reads a multiplexed, active-high 7-segment display bus and recovers the hex nibble shown on each digit.
//  Inverse of the team's nibble->segment encoder. Used on test fixtures and loopback paths to check displayed values.
//  Pins are asynchronous to clk. The block synchronises them, waits until the pattern is stable, then decodes it.
//  Segment order: seg[6]=a ... seg[0]=g.
// PARAMETERS
//  N_DIGITS       4    number of digit-select lines (>=1)
//  STABLE_CYCLES  8    consecutive identical synced samples needed before capture (>=1)
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           asynchronous active-low reset
//  seg          in   7           segment lines, active high, asynchronous
//  dig_sel      in   N_DIGITS    digit enables, active high, one-hot when valid, asynchronous
//  digits       out  4*N_DIGITS  last nibble captured per digit; digit i = digits[4i+3:4i]
//  upd_valid    out  1           1-cycle pulse: a capture happened
//  upd_idx      out  clog2(N)    index of captured digit; valid with upd_valid (width min 1)
//  upd_nibble   out  4           decoded value; valid with upd_valid
//  upd_err      out  1           with upd_valid: pattern not in table, nibble forced 0
//  frame_done   out  1           1-cycle pulse: every digit captured at least once since last pulse
// BEHAVIOUR
//  Reset: all outputs 0, sync flops 0, FSM=IDLE, capture mask 0. Reset is asynchronous assert; it may arrive mid-settle and aborts it.
//  Synchroniser: 2-flop on {dig_sel,seg}. Change detect compares sync stage 2 against a 3rd register.
//  FSM:
//   IDLE:   synced dig_sel not one-hot (zero or multi-hot). Stays in IDLE. Goes to SETTLE, cnt=0, when one-hot.
//   SETTLE: if sample == previous sample, cnt++. Any change resets cnt=0.
//           cnt reaches STABLE_CYCLES-1 with an unchanged sample -> capture, go to HOLD.
//   HOLD:   no further captures while the sample is unchanged. Any change -> SETTLE (cnt=0), or IDLE if not one-hot.
//  Not-one-hot dig_sel in any state goes to IDLE the same cycle.
//  Latency: pins held constant from cycle T give upd_valid in cycle T+2+STABLE_CYCLES, exactly.
//  Capture (registered, same cycle as upd_valid):
//   - Writes upd_* and digits[idx].
//   - On upd_err=1, digits[idx] is not written.
//   - Sets mask[idx]; error captures set the mask too.
//  frame_done: asserted the cycle after a capture makes mask all-ones. Mask clears to 0 in the cycle frame_done is asserted.
//  Decode table (seg hex -> nibble):
//   7E=0 30=1 6D=2 79=3 33=4 5B=5 5F=6 70=7 7F=8 7B=9 77=A 1F=B 4E=C 3D=D 4F=E 47=F. Any other pattern -> err.
//  Glitch shorter than STABLE_CYCLES: no capture; count restarts.
// CONFIGURATION
//  SEG7_BLANK_DETECT_EN:
//   Defined: pattern 0x00 is a blank, not an error.
//    - upd_valid pulses with upd_err=0 and upd_nibble=0.
//    - Extra output blank_mask[N_DIGITS] (reset 0): bit idx set on a blank capture, cleared on a non-blank capture of that digit.
//    - digits[idx] is not written on a blank capture.
//   Undefined: 0x00 decodes as error. No blank_mask port.
// STRUCTURE
//  Package seg7_pkg:
//   - 16 pattern localparams SEG7_0..SEG7_F and SEG7_BLANK.
//   - FSM state enum {IDLE,SETTLE,HOLD}.
//   - function seg7_decode(seg) -> {err,nibble}, shared with the encoder's checker.
//  Sub-module seg7_pattern_lookup: combinational seg->{err,nibble} wrapper around the package function.
//  Onehot check, counter, FSM and capture registers live in the top.
// TESTING
//  1 Reset: rst_n=0 mid-SETTLE -> all outputs 0 immediately; no upd_valid for >=STABLE_CYCLES+2 cycles after release.
//  2 dig_sel=0001, seg=7'h5B held from T -> upd_valid exactly at T+10 (defaults); idx=0, nibble=5, err=0; digits[3:0]=5.
//  3 Scan digits 0..3 with 30,6D,79,47, each held 12 cycles:
//    -> four captures; frame_done one cycle after the 4th; digits=16'hF321.
//  4 seg toggles 7E<->30 every 5 cycles with dig_sel fixed -> no upd_valid. Then hold 30 -> one capture of 1.
//  5 dig_sel=0011 for 20 cycles -> IDLE, no capture. Then dig_sel=0100, seg=7'h12 -> upd_err=1, nibble=0, digits[11:8] unchanged.
//  6 seg=7'h00 held on digit 1 -> err=1 with macro undefined; err=0 and blank_mask=0010 with SEG7_BLANK_DETECT_EN defined.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: pattern constants (seg[6]=a .. seg[0]=g),
// reader FSM state encoding and the pattern -> {err, nibble} decoder.
package seg7_pkg;

    localparam logic [6:0] SEG7_0     = 7'h7E;
    localparam logic [6:0] SEG7_1     = 7'h30;
    localparam logic [6:0] SEG7_2     = 7'h6D;
    localparam logic [6:0] SEG7_3     = 7'h79;
    localparam logic [6:0] SEG7_4     = 7'h33;
    localparam logic [6:0] SEG7_5     = 7'h5B;
    localparam logic [6:0] SEG7_6     = 7'h5F;
    localparam logic [6:0] SEG7_7     = 7'h70;
    localparam logic [6:0] SEG7_8     = 7'h7F;
    localparam logic [6:0] SEG7_9     = 7'h7B;
    localparam logic [6:0] SEG7_A     = 7'h77;
    localparam logic [6:0] SEG7_B     = 7'h1F;
    localparam logic [6:0] SEG7_C     = 7'h4E;
    localparam logic [6:0] SEG7_D     = 7'h3D;
    localparam logic [6:0] SEG7_E     = 7'h4F;
    localparam logic [6:0] SEG7_F     = 7'h47;
    localparam logic [6:0] SEG7_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } seg7_state_e;

    // Returns {err, nibble}; unknown patterns give err=1 with nibble forced to 0.
    function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            SEG7_0:  res = {1'b0, 4'h0};
            SEG7_1:  res = {1'b0, 4'h1};
            SEG7_2:  res = {1'b0, 4'h2};
            SEG7_3:  res = {1'b0, 4'h3};
            SEG7_4:  res = {1'b0, 4'h4};
            SEG7_5:  res = {1'b0, 4'h5};
            SEG7_6:  res = {1'b0, 4'h6};
            SEG7_7:  res = {1'b0, 4'h7};
            SEG7_8:  res = {1'b0, 4'h8};
            SEG7_9:  res = {1'b0, 4'h9};
            SEG7_A:  res = {1'b0, 4'hA};
            SEG7_B:  res = {1'b0, 4'hB};
            SEG7_C:  res = {1'b0, 4'hC};
            SEG7_D:  res = {1'b0, 4'hD};
            SEG7_E:  res = {1'b0, 4'hE};
            SEG7_F:  res = {1'b0, 4'hF};
            default: res = {1'b1, 4'h0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_scan_reader_if.sv
// Bus between a multiplexed 7-segment display and seg7_scan_reader.
// slave = the reader (samples pins, drives results); master = the display side.
// Optional SEG7_BLANK_DETECT_EN adds blank_mask.
interface seg7_scan_reader_if #(
    parameter int N_DIGITS = 4
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [6:0]            seg;
    logic [N_DIGITS-1:0]   dig_sel;
    logic [4*N_DIGITS-1:0] digits;
    logic                  upd_valid;
    logic [IDX_W-1:0]      upd_idx;
    logic [3:0]            upd_nibble;
    logic                  upd_err;
    logic                  frame_done;
`ifdef SEG7_BLANK_DETECT_EN
    logic [N_DIGITS-1:0]   blank_mask;

    modport master (output seg, dig_sel,
                    input  digits, upd_valid, upd_idx, upd_nibble, upd_err, frame_done, blank_mask);
    modport slave  (input  seg, dig_sel,
                    output digits, upd_valid, upd_idx, upd_nibble, upd_err, frame_done, blank_mask);
`else
    modport master (output seg, dig_sel,
                    input  digits, upd_valid, upd_idx, upd_nibble, upd_err, frame_done);
    modport slave  (input  seg, dig_sel,
                    output digits, upd_valid, upd_idx, upd_nibble, upd_err, frame_done);
`endif
endinterface

// File: rtl/seg7_pattern_lookup.sv
// Combinational segment pattern -> {err, nibble} lookup around seg7_decode.
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       err_o,
    output logic [3:0] nibble_o
);

    // Decode the synchronised pattern.
    always_comb begin
        {err_o, nibble_o} = seg7_decode(seg_i);
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers per-digit hex nibbles from an asynchronous multiplexed 7-segment bus.
// Pins pass a 2-flop synchroniser; a third register detects change. A sample must
// stay identical for STABLE_CYCLES synced cycles before it is captured.
// Optional SEG7_BLANK_DETECT_EN treats pattern 0x00 as a blank instead of an error.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_reader_if.slave bus
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int SMP_W = N_DIGITS + 7;
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [N_DIGITS-1:0] SEL_ONE   = N_DIGITS'(1);
    localparam logic [N_DIGITS-1:0] MASK_FULL = {N_DIGITS{1'b1}};

    logic [SMP_W-1:0]      sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    seg7_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0]      upd_idx_q, upd_idx_d;
    logic [3:0]            upd_nibble_q, upd_nibble_d;
    logic                  upd_err_q, upd_err_d;
    logic                  frame_done_q, frame_done_d;
    logic [N_DIGITS-1:0]   mask_q, mask_d;
    logic [4*N_DIGITS-1:0] digits_q, digits_d;

    logic [N_DIGITS-1:0]   sel_s;
    logic [6:0]            seg_s;
    logic                  onehot_s, changed_s, cap_s, lk_err_s;
    logic [3:0]            lk_nib_s;
    logic [IDX_W-1:0]      idx_s;

    assign sel_s     = sync2_q[SMP_W-1:7];
    assign seg_s     = sync2_q[6:0];
    assign onehot_s  = (sel_s != {N_DIGITS{1'b0}}) && ((sel_s & (sel_s - SEL_ONE)) == {N_DIGITS{1'b0}});
    assign changed_s = (sync2_q != prev_q);

    seg7_pattern_lookup u_lookup (
        .seg_i    (seg_s),
        .err_o    (lk_err_s),
        .nibble_o (lk_nib_s)
    );

    // Synchroniser chain plus change-detect register.
    always_comb begin
        sync1_d = {bus.dig_sel, bus.seg};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // One-hot select -> digit index.
    always_comb begin
        idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < N_DIGITS; i++) begin
            idx_s = sel_s[i] ? IDX_W'(i) : idx_s;
        end
    end

    // FSM next state and stability counter; capture when cnt reaches STABLE_CYCLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_s   = 1'b0;
        if (!onehot_s) begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
                SETTLE: begin
                    state_d = SETTLE;
                    cnt_d   = changed_s ? {CNT_W{1'b0}} : (cnt_q + CNT_ONE);
                end
                HOLD: begin
                    if (changed_s) begin
                        state_d = SETTLE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = HOLD;
                        cnt_d   = cnt_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
            if ((state_d == SETTLE) && (cnt_d == CNT_LAST)) begin
                cap_s   = 1'b1;
                state_d = HOLD;
            end else begin
                cap_s   = 1'b0;
            end
        end
    end

`ifdef SEG7_BLANK_DETECT_EN
    logic                blank_s;
    logic [N_DIGITS-1:0] blank_mask_q, blank_mask_d;

    assign blank_s        = (seg_s == SEG7_BLANK);
    assign bus.blank_mask = blank_mask_q;

    // Blank flags: set on a blank capture, cleared by any other capture of that digit.
    always_comb begin
        blank_mask_d = blank_mask_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            blank_mask_d[i] = (cap_s && sel_s[i]) ? blank_s : blank_mask_q[i];
        end
    end

    // Blank flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_mask_q <= {N_DIGITS{1'b0}};
        end else begin
            blank_mask_q <= blank_mask_d;
        end
    end
`endif

    // Capture results, digit store, frame mask and frame_done pulse.
    always_comb begin
        upd_valid_d  = cap_s;
        upd_idx_d    = cap_s ? idx_s : upd_idx_q;
        upd_nibble_d = cap_s ? lk_nib_s : upd_nibble_q;
`ifdef SEG7_BLANK_DETECT_EN
        upd_err_d    = cap_s ? (lk_err_s && !blank_s) : upd_err_q;
`else
        upd_err_d    = cap_s ? lk_err_s : upd_err_q;
`endif
        frame_done_d = (mask_q == MASK_FULL);
        mask_d       = frame_done_d ? {N_DIGITS{1'b0}} : mask_q;
        digits_d     = digits_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            // Blank (0x00) is not in the table, so lk_err_s also blocks blank writes.
            mask_d[i]            = (cap_s && sel_s[i]) ? 1'b1 : mask_d[i];
            digits_d[4*i +: 4]   = (cap_s && sel_s[i] && !lk_err_s) ? lk_nib_s : digits_q[4*i +: 4];
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= {SMP_W{1'b0}};
            sync2_q      <= {SMP_W{1'b0}};
            prev_q       <= {SMP_W{1'b0}};
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            upd_valid_q  <= 1'b0;
            upd_idx_q    <= {IDX_W{1'b0}};
            upd_nibble_q <= 4'h0;
            upd_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            mask_q       <= {N_DIGITS{1'b0}};
            digits_q     <= {(4*N_DIGITS){1'b0}};
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            upd_valid_q  <= upd_valid_d;
            upd_idx_q    <= upd_idx_d;
            upd_nibble_q <= upd_nibble_d;
            upd_err_q    <= upd_err_d;
            frame_done_q <= frame_done_d;
            mask_q       <= mask_d;
            digits_q     <= digits_d;
        end
    end

    assign bus.digits     = digits_q;
    assign bus.upd_valid  = upd_valid_q;
    assign bus.upd_idx    = upd_idx_q;
    assign bus.upd_nibble = upd_nibble_q;
    assign bus.upd_err    = upd_err_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (N_DIGITS=4, STABLE_CYCLES=8).
// Inputs change and outputs are sampled on the falling edge.
// Honours SEG7_BLANK_DETECT_EN for the blank-pattern step.
module tb_seg7_scan_reader;

    localparam int N = 4;
    localparam int S = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seg7_scan_reader_if #(.N_DIGITS(N)) bus ();

    seg7_scan_reader #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] seg);
        bus.dig_sel = sel;
        bus.seg     = seg;
    endtask

    // Step n falling edges; upd_valid must pulse only at step kcap, frame_done only at kfd (0 = never).
    task automatic hold(input int n, input int kcap, input int kfd, input string tag);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk({tag, "_upd_valid"}, {31'd0, bus.upd_valid}, {31'd0, (k == kcap)});
            chk({tag, "_frame_done"}, {31'd0, bus.frame_done}, {31'd0, (k == kfd)});
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_digits"}, {16'd0, bus.digits}, 32'd0);
        chk({tag, "_upd_valid"}, {31'd0, bus.upd_valid}, 32'd0);
        chk({tag, "_upd_idx"}, {30'd0, bus.upd_idx}, 32'd0);
        chk({tag, "_upd_nibble"}, {28'd0, bus.upd_nibble}, 32'd0);
        chk({tag, "_upd_err"}, {31'd0, bus.upd_err}, 32'd0);
        chk({tag, "_frame_done"}, {31'd0, bus.frame_done}, 32'd0);
`ifdef SEG7_BLANK_DETECT_EN
        chk({tag, "_blank_mask"}, {28'd0, bus.blank_mask}, 32'd0);
`endif
    endtask

    task automatic chk_upd(input string tag, input logic [1:0] idx, input logic [3:0] nib,
                           input logic err, input logic [15:0] digs);
        chk({tag, "_idx"}, {30'd0, bus.upd_idx}, {30'd0, idx});
        chk({tag, "_nibble"}, {28'd0, bus.upd_nibble}, {28'd0, nib});
        chk({tag, "_err"}, {31'd0, bus.upd_err}, {31'd0, err});
        chk({tag, "_digits"}, {16'd0, bus.digits}, {16'd0, digs});
    endtask

    logic [6:0] t3_seg [4];
    logic [3:0] t3_nib [4];
    logic [3:0] sel_v;

    initial begin
        t3_seg = '{7'h30, 7'h6D, 7'h79, 7'h47};
        t3_nib = '{4'h1, 4'h2, 4'h3, 4'hF};

        // Power-on reset.
        rst_n = 1'b0;
        drive(4'b0000, 7'h00);
        repeat (3) @(negedge clk);
        chk_zero("por");
        rst_n = 1'b1;
        hold(3, 0, 0, "idle");

        // Single digit 0 showing 5: pulse exactly 10 cycles after the pins change.
        drive(4'b0001, 7'h5B);
        hold(12, 10, 0, "t2");
        chk_upd("t2", 2'd0, 4'h5, 1'b0, 16'h0005);
        hold(10, 0, 0, "t2_hold");

        // Scan all four digits; frame_done one cycle after the 4th capture.
        for (int d = 0; d < 4; d++) begin
            sel_v = 4'b0001 << d;
            drive(sel_v, t3_seg[d]);
            hold(12, 10, (d == 3) ? 11 : 0, "t3");
            chk_upd("t3", 2'(d), t3_nib[d], 1'b0, (d == 3) ? 16'hF321 : 16'h0000 | bus.digits);
        end
        chk("t3_digits", {16'd0, bus.digits}, 32'h0000F321);

        // Glitching segments (5-cycle toggles) never capture; then holding 1 captures.
        for (int t = 0; t < 6; t++) begin
            drive(4'b0010, (t % 2 == 0) ? 7'h7E : 7'h30);
            hold(5, 0, 0, "t4_glitch");
        end
        hold(12, 5, 0, "t4_settle");
        chk_upd("t4", 2'd1, 4'h1, 1'b0, 16'hF311);

        // Multi-hot select stays idle; then an unknown pattern on digit 2 flags err.
        drive(4'b0011, 7'h7E);
        hold(20, 0, 0, "t5_multihot");
        drive(4'b0100, 7'h12);
        hold(12, 10, 0, "t5_err");
        chk_upd("t5", 2'd2, 4'h0, 1'b1, 16'hF311);

        // All-segments-off on digit 1.
        drive(4'b0010, 7'h00);
        hold(12, 10, 0, "t6");
`ifdef SEG7_BLANK_DETECT_EN
        chk_upd("t6_blank", 2'd1, 4'h0, 1'b0, 16'hF311);
        chk("t6_blank_mask", {28'd0, bus.blank_mask}, 32'h00000002);
`else
        chk_upd("t6_err", 2'd1, 4'h0, 1'b1, 16'hF311);
`endif

        // Asynchronous reset in the middle of settling, then recovery.
        drive(4'b0001, 7'h4F);
        hold(5, 0, 0, "t1_settle");
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t1_async");
        repeat (2) @(negedge clk);
        chk_zero("t1_held");
        rst_n = 1'b1;
        hold(12, 10, 0, "t1_release");
        chk_upd("t1", 2'd0, 4'hE, 1'b0, 16'h000E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
